// File: rtl/cnt_sample_fifo.sv
// Decimating sampler for the up/down counter: captures {sample, delta-to-previous}
// into a show-ahead FIFO drained over valid/ready, with drop counting and invalid-value flag.
module cnt_sample_fifo #(
    parameter int DEPTH   = 8,
    parameter int DECIM   = 4,
    parameter int RST_VAL = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [9:0]          cnt_in,
    input  logic                       capture_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [9:0]          out_data,
    output logic signed [10:0]         out_delta,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 drop_cnt,
    output logic                       inv_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0]       DCNT_LAST = DW'(DECIM - 1);
    localparam logic [AW:0]         FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic signed [9:0]   PREV_INIT = 10'(RST_VAL);

    logic signed [9:0]  mem_data  [DEPTH];
    logic signed [10:0] mem_delta [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [DW-1:0]      dcnt;
    logic signed [9:0]  prev;

    logic               capture, full, pop, push, drop, invalid;
    logic signed [10:0] delta;

    always_comb begin
        capture   = capture_en && (dcnt == DCNT_LAST);
        full      = (level == FULL_LVL);
        out_valid = (level != '0);
        pop       = out_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = capture && (!full || pop);
        drop      = capture && full && !pop;
        delta     = {cnt_in[9], cnt_in} - {prev[9], prev};
        invalid   = (cnt_in == -10'sd47) || (cnt_in < -10'sd263) || (cnt_in > 10'sd269);
        out_data  = out_valid ? mem_data[rptr]  : '0;
        out_delta = out_valid ? mem_delta[rptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            dcnt     <= '0;
            prev     <= PREV_INIT;
            drop_cnt <= '0;
            inv_err  <= 1'b0;
        end else begin
            if (capture_en)
                dcnt <= capture ? '0 : dcnt + 1'b1;
            if (push) begin
                wptr <= wptr + 1'b1;
                prev <= cnt_in;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (capture && invalid)
                inv_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr]  <= cnt_in;
            mem_delta[wptr] <= delta;
        end
    end

endmodule
